fp32_mul_arbiter: RTL and testbench

//  Shares one combinational fp32_multiplier between NUM_REQ requesters (e.g. neuron lanes of the

---
 rtl/fp32_mul_arbiter.sv | 120 ++++++++++++
 tb/tb_fp32_mul_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_mul_arbiter.sv
// Round-robin arbiter sharing one external combinational fp32 multiplier between NUM_REQ requesters.
// Two-stage register pipeline; optional perf counters when FP_MUL_ARB_PERF_EN is defined.
module fp32_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  output logic [31:0]            mul_a,
  output logic [31:0]            mul_b,
  input  logic [31:0]            mul_product,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [31:0]            rsp_data,
  output logic [ID_W-1:0]        rsp_id
`ifdef FP_MUL_ARB_PERF_EN
  ,
  output logic [31:0]            perf_ops,
  output logic [31:0]            perf_stall
`endif
);

  // valid/ready: a transfer happens on an edge where both are high; a raised valid
  // holds with stable data until accepted, and req_ready may follow req_valid combinationally.

  logic                 s1_v_q, s2_v_q;
  logic [31:0]          s1_a_q, s1_b_q, s2_data_q;
  logic [ID_W-1:0]      s1_id_q, s2_id_q;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                 any_grant, s1_ld, s2_ld;
  logic [ID_W-1:0]      grant_idx;
  logic [31:0]          gnt_a, gnt_b;

  // Scan from rr_ptr upward, wrapping, and grant the first valid requester.
  always_comb begin : arb
    int idx;
    any_grant = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_grant && req_valid[idx]) begin
        any_grant = 1'b1;
        grant_idx = idx[ID_W-1:0];
      end
    end
  end

  assign gnt_a    = req_a[32*grant_idx +: 32];
  assign gnt_b    = req_b[32*grant_idx +: 32];
  assign rr_ptr_d = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;

  assign s2_ld = s1_v_q && (!s2_v_q || rsp_ready);
  assign s1_ld = any_grant && (!s1_v_q || s2_ld);

  always_comb begin
    req_ready = '0;
    if (s1_ld && !rst) req_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q    <= 1'b0;
      s2_v_q    <= 1'b0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s1_id_q   <= '0;
      s2_data_q <= '0;
      s2_id_q   <= '0;
      rr_ptr_q  <= '0;
    end else begin
      if (s2_ld) begin
        s2_data_q <= mul_product;
        s2_id_q   <= s1_id_q;
        s2_v_q    <= 1'b1;
      end else if (rsp_ready) begin
        s2_v_q    <= 1'b0;
      end
      if (s1_ld) begin
        s1_a_q   <= gnt_a;
        s1_b_q   <= gnt_b;
        s1_id_q  <= grant_idx;
        s1_v_q   <= 1'b1;
        rr_ptr_q <= rr_ptr_d;
      end else if (s2_ld) begin
        s1_v_q   <= 1'b0;
      end
    end
  end

  assign mul_a     = s1_a_q;
  assign mul_b     = s1_b_q;
  assign rsp_valid = s2_v_q && !rst;
  assign rsp_data  = s2_data_q;
  assign rsp_id    = s2_id_q;

`ifdef FP_MUL_ARB_PERF_EN
  logic [31:0] perf_ops_q, perf_stall_q;

  // Both counters wrap naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ops_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      if (s1_ld) perf_ops_q <= perf_ops_q + 32'd1;
      if (|req_valid && !s1_ld) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_ops   = perf_ops_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_fp32_mul_arbiter.sv
// Directed bench for fp32_mul_arbiter: requester count model, small fp32 multiplier stub,
// response scoreboard and accept-order log.
module tb_fp32_mul_arbiter;
  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready;
  logic [32*N-1:0] req_a, req_b;
  logic [31:0]     mul_a, mul_b, mul_product;
  logic            rsp_valid, rsp_ready;
  logic [31:0]     rsp_data;
  logic [1:0]      rsp_id;
`ifdef FP_MUL_ARB_PERF_EN
  logic [31:0]     perf_ops, perf_stall;
`endif

  int           cnt[N];
  logic [N-1:0] acc_mask;
  logic [31:0]  op_a[N], op_b[N], exp_tab[N];
  logic [33:0]  exp_q[$];
  logic [33:0]  exp_e;
  int           acc_q[$];
  int           acc_t[$];
  int           ord[8];
  int           cyc = 0;
  int           total = 0;
  int           bad = 0;

  fp32_mul_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_product(mul_product),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id)
`ifdef FP_MUL_ARB_PERF_EN
    , .perf_ops(perf_ops), .perf_stall(perf_stall)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // Normal-number fp32 multiply (truncating); enough for the directed operands.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] m;
    int          e;
    logic        s;
    s = a[31] ^ b[31];
    if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {s, 31'd0};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    m = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    if (m[47]) begin
      e = e + 1;
      return {s, e[7:0], m[46:24]};
    end
    return {s, e[7:0], m[45:23]};
  endfunction

  always_comb mul_product = fmul(mul_a, mul_b);

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_valid[i]        = (cnt[i] != 0);
      req_a[32*i +: 32]   = op_a[i];
      req_b[32*i +: 32]   = op_b[i];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    cyc++;
    acc_mask = '0;
    if (rst) begin
      exp_q.delete();
    end else begin
      check("ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 64'd1, 64'd0);
        end else begin
          exp_e = exp_q.pop_front();
          check("rsp_id", 64'(rsp_id), 64'(exp_e[33:32]));
          check("rsp_data", 64'(rsp_data), 64'(exp_e[31:0]));
        end
      end
      for (int i = 0; i < N; i++) begin
        if (req_ready[i] && req_valid[i]) begin
          acc_mask[i] = 1'b1;
          exp_q.push_back({2'(i), exp_tab[i]});
          acc_q.push_back(i);
          acc_t.push_back(cyc);
        end
      end
    end
  end

  // ---------------- requester driver ----------------
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++)
      if (acc_mask[i] && cnt[i] > 0) cnt[i] = cnt[i] - 1;
  end

  task automatic do_reset();
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((cnt[0] != 0 || cnt[1] != 0 || cnt[2] != 0 || cnt[3] != 0 || exp_q.size() != 0)
           && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check("drain_timeout", 64'd0, 64'd1);
  endtask

  task automatic chk_order(input string tag, input int n);
    check({tag, "_count"}, 64'(acc_q.size()), 64'(n));
    for (int k = 0; k < n; k++)
      check(tag, 64'((k < acc_q.size()) ? acc_q[k] : -1), 64'(ord[k]));
  endtask

  // ---------------- directed tests ----------------
  initial begin
    rst       = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    op_a    = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    op_b    = '{32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000};
    exp_tab = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000};

    // reset state, with a request already pending
    repeat (2) @(posedge clk);
    #2 cnt[0] = 1;
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_mul_a", 64'(mul_a), 64'd0);
    check("rst_mul_b", 64'(mul_b), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_rsp_id", 64'(rsp_id), 64'd0);

    // single op 1.0 x 2.0 from requester 0
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    check("t1_ready", 64'(req_ready), 64'b0001);
    @(negedge clk);
    check("t1_valid_early", 64'(rsp_valid), 64'd0);
    check("t1_mul_a", 64'(mul_a), 64'h3F800000);
    check("t1_mul_b", 64'(mul_b), 64'h40000000);
    @(negedge clk);
    check("t1_valid", 64'(rsp_valid), 64'd1);
    check("t1_data", 64'(rsp_data), 64'h40000000);
    check("t1_id", 64'(rsp_id), 64'd0);
    @(negedge clk);
    check("t1_valid_drop", 64'(rsp_valid), 64'd0);

    // all four requesters, rr_ptr=0: 0,1,2,3,0,1,2,3 at one per clock
    do_reset();
    acc_q.delete(); acc_t.delete();
    for (int i = 0; i < N; i++) cnt[i] = 2;
    drain(100);
    ord = '{0, 1, 2, 3, 0, 1, 2, 3};
    chk_order("t2_order", 8);
    check("t2_rate", 64'((acc_t.size() == 8) ? acc_t[7] - acc_t[0] : -1), 64'd7);

    // backpressure: 5 cycles of rsp_ready=0 with three requesters valid
    @(posedge clk); #2;
    acc_q.delete();
    rsp_ready = 1'b0;
    cnt[0] = 1; cnt[1] = 1; cnt[2] = 1;
    repeat (3) @(negedge clk);
    check("t3_data_hold0", 64'(rsp_data), 64'h40000000);
    check("t3_ready_off0", 64'(req_ready), 64'd0);
    repeat (2) @(negedge clk);
    check("t3_accepts", 64'(acc_q.size()), 64'd2);
    check("t3_ready_off1", 64'(req_ready), 64'd0);
    check("t3_valid_hold", 64'(rsp_valid), 64'd1);
    check("t3_data_hold1", 64'(rsp_data), 64'h40000000);
    @(posedge clk); #2 rsp_ready = 1'b1;
    drain(100);
    ord = '{0, 1, 2, 0, 0, 0, 0, 0};
    chk_order("t3_order", 3);

    // wrap/skip: move rr_ptr to 2, then only req3 and req1 valid; 3.0 x -2.0 on req3
    @(posedge clk); #2;
    cnt[1] = 1;
    drain(100);
    @(posedge clk); #2;
    acc_q.delete();
    op_a[3] = 32'h40400000; op_b[3] = 32'hC0000000; exp_tab[3] = 32'hC0C00000;
    cnt[1] = 1; cnt[3] = 1;
    drain(100);
    ord = '{3, 1, 0, 0, 0, 0, 0, 0};
    chk_order("t4_order", 2);
    op_a[3] = 32'h40800000; op_b[3] = 32'h40000000; exp_tab[3] = 32'h41000000;

    // reset with FULL pipeline (rr_ptr ends at 1), then lowest valid index wins
    @(posedge clk); #2;
    rsp_ready = 1'b0;
    cnt[2] = 2; cnt[0] = 1;
    repeat (3) @(negedge clk);
    check("t5_full_valid", 64'(rsp_valid), 64'd1);
    check("t5_full_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #2;
    rst = 1'b1; cnt[0] = 1; cnt[3] = 1;
    @(negedge clk);
    check("t5_rst_valid", 64'(rsp_valid), 64'd0);
    check("t5_rst_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #2;
    rst = 1'b0; rsp_ready = 1'b1;
    acc_q.delete();
    @(negedge clk);
    check("t5_post_valid", 64'(rsp_valid), 64'd0);
    check("t5_post_ready", 64'(req_ready), 64'b0001);
    drain(100);
    ord = '{0, 2, 3, 0, 0, 0, 0, 0};
    chk_order("t5_order", 3);

`ifdef FP_MUL_ARB_PERF_EN
    // 10 accepts, 4 stalled cycles, then wrap of perf_ops
    do_reset();
    rsp_ready = 1'b0;
    cnt[0] = 3;
    repeat (6) @(posedge clk);
    #2 rsp_ready = 1'b1;
    cnt[1] = 7;
    drain(100);
    check("t6_perf_ops", 64'(perf_ops), 64'd10);
    check("t6_perf_stall", 64'(perf_stall), 64'd4);
    @(negedge clk);
    force dut.perf_ops_q = 32'hFFFFFFFF;
    #1 release dut.perf_ops_q;
    @(posedge clk); #2 cnt[2] = 1;
    drain(100);
    check("t6_perf_wrap", 64'(perf_ops), 64'd0);
    check("t6_stall_keep", 64'(perf_stall), 64'd4);
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
